// File: rtl/fft_sample_loader.sv
// Wishbone write-only master that frames a sample stream into the FFT peripheral:
// control write, 2^LGFFT data writes, then wait for the FFT interrupt before re-arming.
module fft_sample_loader #(
    parameter int unsigned LGFFT     = 10,
    parameter int unsigned LGTIMEOUT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic                i_clr_err,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [31:0]         s_data,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [LGFFT:0]      o_wb_addr,
    output logic [31:0]         o_wb_data,
    input  logic                i_wb_stall,
    input  logic                i_wb_ack,
    input  logic                i_wb_err,
    input  logic                i_fft_int,
    output logic                o_busy,
    output logic [15:0]         o_frame_count,
    output logic                o_err
);

    localparam int unsigned AW  = LGFFT + 1;
    localparam int unsigned IW  = LGFFT;
    localparam int unsigned DW  = 32;
    localparam int unsigned FCW = 16;
    localparam int unsigned TW  = LGTIMEOUT;
    localparam logic [TW-1:0] TMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        LOAD,
        WAIT_INT
    } state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   index_q, index_d;
    logic [FCW-1:0]  frame_q, frame_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            bus_fault;

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            index_q <= index_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, bus sequencing and fault handling
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        addr_d    = addr_q;
        data_d    = data_q;
        index_d   = index_q;
        frame_d   = frame_q;
        err_d     = err_q;
        timer_d   = '0;
        bus_fault = 1'b0;

        if (cyc_q) begin
            if (stb_q && !i_wb_stall) begin
                stb_d = 1'b0;
            end
            if (!i_wb_ack) begin
                timer_d = timer_q + 1'b1;
            end
            bus_fault = i_wb_err || (!i_wb_ack && (timer_d == TMAX));
        end

        case (state_q)
            IDLE: begin
                if (i_clr_err) begin
                    err_d = 1'b0;
                end
                if (i_en && !err_q) begin
                    state_d = CTRL;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                end
            end
            CTRL: begin
                if (cyc_q && i_wb_ack) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    index_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cyc_q) begin
                    if (i_wb_ack) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        index_d = index_q + 1'b1;
                        if (index_q == '1) begin
                            state_d = WAIT_INT;
                        end
                    end
                end else if (s_valid && ready_q) begin
                    cyc_d  = 1'b1;
                    stb_d  = 1'b1;
                    addr_d = {1'b1, index_q};
                    data_d = s_data;
                end
            end
            WAIT_INT: begin
                // The interrupt is only honoured here, so a stale level after CTRL is harmless
                if (i_fft_int) begin
                    frame_d = frame_q + 1'b1;
                    if (i_en) begin
                        state_d = CTRL;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        addr_d  = '0;
                        data_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus error outranks a simultaneous ack
        if (bus_fault) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            timer_d = '0;
            state_d = IDLE;
        end

        ready_d = (state_d == LOAD) && !cyc_d;
        busy_d  = (state_d != IDLE);
    end

    assign s_ready       = ready_q;
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = stb_q;
    assign o_wb_we       = 1'b1;
    assign o_wb_addr     = addr_q;
    assign o_wb_data     = data_q;
    assign o_busy        = busy_q;
    assign o_frame_count = frame_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: scripted slave/source, transaction-level frame model
// checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fft_sample_loader;

    localparam int LGFFT  = 3;
    localparam int LGTO   = 4;
    localparam int AW     = LGFFT + 1;
    localparam int NS     = 1 << LGFFT;
    localparam int TO_CYC = (1 << LGTO) - 1;

    logic            clk;
    logic            i_reset, i_en, i_clr_err;
    logic            s_valid, s_ready;
    logic [31:0]     s_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [31:0]     o_wb_data;
    logic            i_wb_stall, i_wb_ack, i_wb_err, i_fft_int;
    logic            o_busy;
    logic [15:0]     o_frame_count;
    logic            o_err;

    fft_sample_loader #(.LGFFT(LGFFT), .LGTIMEOUT(LGTO)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_clr_err(i_clr_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_fft_int(i_fft_int), .o_busy(o_busy), .o_frame_count(o_frame_count), .o_err(o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scenario knobs, written only by the test sequence
    int stall_cfg    = 0;
    int suppress_idx = -1;
    bit err_on_ctrl  = 1'b0;
    bit valid_toggle = 1'b0;

    // Model and monitor state, written only by the compare process
    logic [15:0]    exp_frames = '0;
    bit             exp_err = 1'b0;
    int             w = 0;
    int             acked = 0;
    bit             waiting = 1'b0;
    int             run = 0;
    logic [31:0]    sq[$];
    int             hs_cnt = 0;
    int             wr_cnt = 0;
    int             data_cnt = 0;
    logic [AW-1:0]  last_addr = '0;
    logic [31:0]    last_data = '0;
    int             cyc_run = 0, cyc_run_last = 0;
    int             stb_run = 0, stb_run_last = 0;
    bit             ready_seen = 1'b0;
    bit             prev_reset = 1'b0, prev_acc = 1'b0, prev_hold = 1'b0, abort_prev = 1'b0;
    logic [AW-1:0]  prev_addr = '0;
    logic [31:0]    prev_data = '0;

    // Wishbone slave: stall_cfg stalls per request, ack one cycle after acceptance
    initial begin
        int  stall_left;
        bit  pend;
        bit  pend_ctrl;
        int  pend_idx;
        int  dcount;
        stall_left = 0; pend = 1'b0; pend_ctrl = 1'b0; pend_idx = 0; dcount = 0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            i_wb_ack = 1'b0;
            i_wb_err = 1'b0;
            if (i_reset) begin
                i_wb_stall = 1'b0;
                pend = 1'b0;
                stall_left = stall_cfg;
                dcount = 0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (pend_ctrl && err_on_ctrl) begin
                        i_wb_err = 1'b1;
                        i_wb_ack = 1'b1;
                    end else if (pend_ctrl || pend_idx != suppress_idx) begin
                        i_wb_ack = 1'b1;
                    end
                end
                if (o_wb_cyc && o_wb_stb) begin
                    if (stall_left > 0) begin
                        i_wb_stall = 1'b1;
                        stall_left--;
                    end else begin
                        i_wb_stall = 1'b0;
                        pend = 1'b1;
                        pend_ctrl = !o_wb_addr[AW-1];
                        pend_idx = dcount;
                        if (o_wb_addr[AW-1]) dcount++;
                        stall_left = stall_cfg;
                    end
                end else begin
                    i_wb_stall = 1'b0;
                end
            end
        end
    end

    // Sample source: n-th accepted sample carries 0x0001_0000 + n
    initial begin
        bit ph;
        ph = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        forever begin
            @(posedge clk); #1;
            ph = ~ph;
            s_valid = valid_toggle ? ph : 1'b1;
            s_data = 32'h0001_0000 + 32'(hs_cnt);
        end
    end

    task automatic model_abort();
        exp_err = 1'b1;
        abort_prev = 1'b1;
        w = 0;
        acked = 0;
        waiting = 1'b0;
        run = 0;
        sq.delete();
    endtask

    // Compare process: check outputs, then advance the frame model on this cycle's inputs
    initial begin
        logic [AW-1:0] exp_a;
        logic [31:0]   d;
        forever begin
            @(negedge clk);
            chk("we_high", 64'(o_wb_we), 64'(1));
            if (prev_reset)
                chk("reset_outputs", 64'({o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_data, s_ready,
                                          o_busy, o_frame_count, o_err}), 64'(0));
            chk("frame_count", 64'(o_frame_count), 64'(exp_frames));
            chk("err_flag", 64'(o_err), 64'(exp_err));
            chk("ready_while_cyc", 64'(s_ready && o_wb_cyc), 64'(0));
            if (prev_acc) chk("stb_drop_after_accept", 64'(o_wb_stb), 64'(0));
            if (prev_hold && o_wb_stb)
                chk("hold_addr_data", 64'({o_wb_addr, o_wb_data}), 64'({prev_addr, prev_data}));
            if (abort_prev) chk("cyc_drop_on_abort", 64'(o_wb_cyc), 64'(0));

            abort_prev = 1'b0;
            prev_acc = 1'b0;
            prev_hold = 1'b0;
            if (i_reset) begin
                prev_reset = 1'b1;
                exp_frames = '0; exp_err = 1'b0; w = 0; acked = 0; waiting = 1'b0; run = 0;
                sq.delete();
                hs_cnt = 0; wr_cnt = 0; data_cnt = 0; ready_seen = 1'b0;
                cyc_run = 0; stb_run = 0;
            end else begin
                prev_reset = 1'b0;
                if (waiting && i_fft_int) begin
                    exp_frames = exp_frames + 16'd1;
                    waiting = 1'b0;
                end
                if (i_clr_err) exp_err = 1'b0;
                if (s_ready) ready_seen = 1'b1;
                if (o_wb_cyc) cyc_run++;
                else if (cyc_run != 0) begin cyc_run_last = cyc_run; cyc_run = 0; end
                if (o_wb_stb) stb_run++;
                else if (stb_run != 0) begin stb_run_last = stb_run; stb_run = 0; end

                if (o_wb_stb && !i_wb_stall) begin
                    prev_acc = 1'b1;
                    wr_cnt++;
                    if (w == 0) begin
                        chk("ctrl_addr", 64'(o_wb_addr), 64'(0));
                        chk("ctrl_data", 64'(o_wb_data), 64'(0));
                    end else begin
                        exp_a = AW'(NS + w - 1);
                        chk("data_addr", 64'(o_wb_addr), 64'(exp_a));
                        chk("sample_pending", 64'(sq.size() > 0), 64'(1));
                        if (sq.size() > 0) begin
                            d = sq.pop_front();
                            chk("data_value", 64'(o_wb_data), 64'(d));
                        end
                        data_cnt++;
                        last_addr = o_wb_addr;
                        last_data = o_wb_data;
                    end
                    w = (w == NS) ? 0 : w + 1;
                end
                if (o_wb_stb && i_wb_stall) begin
                    prev_hold = 1'b1;
                    prev_addr = o_wb_addr;
                    prev_data = o_wb_data;
                end

                if (o_wb_cyc && i_wb_err) begin
                    model_abort();
                end else if (o_wb_cyc && i_wb_ack) begin
                    run = 0;
                    acked++;
                    if (acked == NS + 1) begin
                        acked = 0;
                        waiting = 1'b1;
                    end
                end else if (o_wb_cyc) begin
                    run++;
                    if (run == TO_CYC) model_abort();
                end else begin
                    run = 0;
                end

                if (s_valid && s_ready) begin
                    sq.push_back(s_data);
                    hs_cnt++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        i_en = 1'b0;
        i_reset = 1'b1;
        tick(2);
        i_reset = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        for (int k = 0; k < 300 && !waiting; k++) tick(1);
        chk(nm, 64'(waiting), 64'(1));
    endtask

    task automatic pulse_int();
        i_fft_int = 1'b1;
        tick(1);
        i_fft_int = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_en = 1'b0; i_clr_err = 1'b0; i_fft_int = 1'b0;
        tick(1);

        // Basic frame, then back-to-back, then i_en dropped mid-frame
        do_reset();
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_frames", 64'(o_frame_count), 64'(0));
        i_en = 1'b1;
        tick(1);
        chk("t1_ctrl_cyc", 64'(o_wb_cyc), 64'(1));
        chk("t1_ctrl_addr", 64'(o_wb_addr), 64'(0));
        wait_frame("t1_frame1_done");
        chk("t1_writes", 64'(wr_cnt), 64'(9));
        chk("t1_data_writes", 64'(data_cnt), 64'(8));
        chk("t1_last_addr", 64'(last_addr), 64'(4'hF));
        chk("t1_last_data", 64'(last_data), 64'(32'h0001_0007));
        chk("t1_wait_ready", 64'(s_ready), 64'(0));
        tick(3);
        chk("t1_no_int_frames", 64'(o_frame_count), 64'(0));
        chk("t1_wait_idle_bus", 64'(o_wb_cyc), 64'(0));
        chk("t1_wait_busy", 64'(o_busy), 64'(1));
        pulse_int();
        chk("t1_frames_1", 64'(o_frame_count), 64'(1));
        chk("t1_rearm_cyc", 64'(o_wb_cyc), 64'(1));
        chk("t1_rearm_addr", 64'(o_wb_addr), 64'(0));
        i_en = 1'b0;
        wait_frame("t1_frame2_done");
        chk("t1_frame2_data", 64'(data_cnt), 64'(16));
        pulse_int();
        chk("t1_frames_2", 64'(o_frame_count), 64'(2));
        tick(2);
        chk("t1_idle_busy", 64'(o_busy), 64'(0));
        chk("t1_idle_cyc", 64'(o_wb_cyc), 64'(0));

        // Two stall cycles per request
        stall_cfg = 2;
        do_reset();
        i_en = 1'b1;
        wait_frame("t2_frame_done");
        chk("t2_stb_len", 64'(stb_run_last), 64'(3));
        chk("t2_cyc_len", 64'(cyc_run_last), 64'(4));
        chk("t2_writes", 64'(wr_cnt), 64'(9));
        chk("t2_queue_empty", 64'(sq.size()), 64'(0));
        i_en = 1'b0;
        pulse_int();
        chk("t2_frames", 64'(o_frame_count), 64'(1));

        // Source valid toggles every cycle
        stall_cfg = 0;
        valid_toggle = 1'b1;
        do_reset();
        i_en = 1'b1;
        wait_frame("t3_frame_done");
        chk("t3_data_writes", 64'(data_cnt), 64'(8));
        chk("t3_last_addr", 64'(last_addr), 64'(4'hF));
        chk("t3_last_data", 64'(last_data), 64'(32'h0001_0007));
        i_en = 1'b0;
        pulse_int();
        chk("t3_frames", 64'(o_frame_count), 64'(1));

        // Fourth data write never acked: timeout abort, no re-arm until cleared
        valid_toggle = 1'b0;
        suppress_idx = 3;
        do_reset();
        i_en = 1'b1;
        for (int k = 0; k < 200 && !o_err; k++) tick(1);
        chk("t4_err", 64'(o_err), 64'(1));
        tick(1);
        chk("t4_timeout_len", 64'(cyc_run_last), 64'(15));
        chk("t4_data_writes", 64'(data_cnt), 64'(4));
        chk("t4_busy", 64'(o_busy), 64'(0));
        tick(10);
        chk("t4_no_rearm_cyc", 64'(o_wb_cyc), 64'(0));
        chk("t4_no_rearm_busy", 64'(o_busy), 64'(0));
        chk("t4_frames", 64'(o_frame_count), 64'(0));
        suppress_idx = -1;
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        chk("t4_cleared", 64'(o_err), 64'(0));
        tick(1);
        chk("t4_rearm_cyc", 64'(o_wb_cyc), 64'(1));
        chk("t4_rearm_addr", 64'(o_wb_addr), 64'(0));

        // Error together with ack on the control write
        err_on_ctrl = 1'b1;
        do_reset();
        i_en = 1'b1;
        for (int k = 0; k < 20 && !o_err; k++) tick(1);
        chk("t5_err", 64'(o_err), 64'(1));
        tick(1);
        chk("t5_writes", 64'(wr_cnt), 64'(1));
        chk("t5_no_load", 64'(ready_seen), 64'(0));
        chk("t5_frames", 64'(o_frame_count), 64'(0));
        chk("t5_busy", 64'(o_busy), 64'(0));
        err_on_ctrl = 1'b0;

        // Reset while index 5 is outstanding
        do_reset();
        i_en = 1'b1;
        for (int k = 0; k < 200 && data_cnt < 6; k++) tick(1);
        chk("t6_mid_cyc", 64'(o_wb_cyc), 64'(1));
        chk("t6_mid_addr", 64'(last_addr), 64'(4'hD));
        i_reset = 1'b1;
        tick(1);
        chk("t6_rst_cyc", 64'(o_wb_cyc), 64'(0));
        chk("t6_rst_busy", 64'(o_busy), 64'(0));
        chk("t6_rst_addr", 64'(o_wb_addr), 64'(0));
        tick(1);
        i_reset = 1'b0;
        tick(1);
        chk("t6_restart_cyc", 64'(o_wb_cyc), 64'(1));
        chk("t6_restart_addr", 64'(o_wb_addr), 64'(0));
        wait_frame("t6_frame_done");
        chk("t6_writes", 64'(wr_cnt), 64'(9));
        chk("t6_last_addr", 64'(last_addr), 64'(4'hF));
        chk("t6_last_data", 64'(last_data), 64'(32'h0001_0007));

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
